// File: rtl/nios2_debug_slave_cmd_queue.sv
// nios2_debug_slave_cmd_queue
//
// System-clock-side receiver for JTAG debug slave commands. The update-DR and
// update-IR strobes from the TCK domain are synchronised and edge-detected.
// Each update-DR rise captures {ir_in, sr} into a small first-word-fall-through
// FIFO that the CPU debug logic drains through a valid/ready handshake.
//
// Ports:
//   clk, reset_n            system clock, asynchronous active-low reset
//   vs_udr, vs_uir          update-DR / update-IR strobes (TCK domain, async)
//   ir_in, sr               IR code and shifted data, quasi-static around strobes
//   cmd_ready               consumer accepts the head command
//   overflow_clr            clears the sticky overflow flag
//   cmd_valid               FIFO holds at least one command
//   cmd_ir, cmd_data        head entry (fall-through)
//   ir_latched, uir_pulse   IR captured at last update-IR, one-cycle pulse per update-IR
//   level                   FIFO occupancy, 0..DEPTH
//   overflow                sticky: a command was dropped because the FIFO was full
//   ack_toggle              inverts on every consumed command
module nios2_debug_slave_cmd_queue #(
  parameter int DATA_W      = 38,
  parameter int IR_W        = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     vs_udr,
  input  logic                     vs_uir,
  input  logic [IR_W-1:0]          ir_in,
  input  logic [DATA_W-1:0]        sr,
  input  logic                     cmd_ready,
  input  logic                     overflow_clr,
  output logic                     cmd_valid,
  output logic [IR_W-1:0]          cmd_ir,
  output logic [DATA_W-1:0]        cmd_data,
  output logic [IR_W-1:0]          ir_latched,
  output logic                     uir_pulse,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     ack_toggle
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = IR_W + DATA_W;
  localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

  // Strobe synchronisers and edge detectors
  logic [SYNC_STAGES-1:0] udr_sync_reg;
  logic [SYNC_STAGES-1:0] uir_sync_reg;
  logic                   udr_prev_reg;
  logic                   uir_prev_reg;
  logic                   udr_rise;
  logic                   uir_rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      udr_sync_reg <= '0;
      uir_sync_reg <= '0;
      udr_prev_reg <= 1'b0;
      uir_prev_reg <= 1'b0;
    end else begin
      udr_sync_reg <= {udr_sync_reg[SYNC_STAGES-2:0], vs_udr};
      uir_sync_reg <= {uir_sync_reg[SYNC_STAGES-2:0], vs_uir};
      udr_prev_reg <= udr_sync_reg[SYNC_STAGES-1];
      uir_prev_reg <= uir_sync_reg[SYNC_STAGES-1];
    end
  end

  assign udr_rise = udr_sync_reg[SYNC_STAGES-1] & ~udr_prev_reg;
  assign uir_rise = uir_sync_reg[SYNC_STAGES-1] & ~uir_prev_reg;

  // FIFO control. The counters carry one extra bit so full and empty are
  // distinguishable; their low bits are the storage pointers.
  logic [AW:0] wr_cnt_reg;
  logic [AW:0] rd_cnt_reg;
  logic        full;
  logic        pop;
  logic        push;
  logic        drop;

  assign level     = wr_cnt_reg - rd_cnt_reg;
  assign cmd_valid = (level != '0);
  assign full      = (level == FULL_LEVEL);
  assign pop       = cmd_valid & cmd_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign push      = udr_rise & (~full | pop);
  assign drop      = udr_rise & full & ~pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt_reg <= '0;
      rd_cnt_reg <= '0;
      ack_toggle <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_cnt_reg <= wr_cnt_reg + 1'b1;
      if (pop) begin
        rd_cnt_reg <= rd_cnt_reg + 1'b1;
        ack_toggle <= ~ack_toggle;
      end
      // A fresh drop wins over a simultaneous clear.
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  // Storage: contents are cleared on reset, so each word is a plain register.
  logic [EW-1:0] mem_reg [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          mem_reg[gi] <= '0;
        end else if (push && (wr_cnt_reg[AW-1:0] == gi[AW-1:0])) begin
          mem_reg[gi] <= {ir_in, sr};
        end
      end
    end
  endgenerate

  assign {cmd_ir, cmd_data} = mem_reg[rd_cnt_reg[AW-1:0]];

  // Update-IR side: latch the IR and emit a single-cycle pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_latched <= '0;
      uir_pulse  <= 1'b0;
    end else begin
      uir_pulse <= uir_rise;
      if (uir_rise) ir_latched <= ir_in;
    end
  end

endmodule

// File: tb/tb_nios2_debug_slave_cmd_queue.sv
// Testbench for nios2_debug_slave_cmd_queue: directed scenarios plus a random
// phase. Stimulus schedules strobe effects; a negedge monitor keeps a queue
// model of the FIFO and compares every DUT output each cycle.
module tb_nios2_debug_slave_cmd_queue;

  localparam int DATA_W = 38;
  localparam int IR_W   = 2;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              vs_udr, vs_uir;
  logic [IR_W-1:0]   ir_in;
  logic [DATA_W-1:0] sr;
  logic              cmd_ready, overflow_clr;
  logic              cmd_valid;
  logic [IR_W-1:0]   cmd_ir;
  logic [DATA_W-1:0] cmd_data;
  logic [IR_W-1:0]   ir_latched;
  logic              uir_pulse;
  logic [2:0]        level;
  logic              overflow, ack_toggle;

  nios2_debug_slave_cmd_queue #(
    .DATA_W(DATA_W), .IR_W(IR_W), .SYNC_STAGES(2), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr), .vs_uir(vs_uir),
    .ir_in(ir_in), .sr(sr), .cmd_ready(cmd_ready), .overflow_clr(overflow_clr),
    .cmd_valid(cmd_valid), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
    .ir_latched(ir_latched), .uir_pulse(uir_pulse), .level(level),
    .overflow(overflow), .ack_toggle(ack_toggle)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Scheduled strobe effects: the edge on which the synchronised rise acts.
  typedef struct {
    int                edge_no;
    bit                is_uir;
    logic [IR_W-1:0]   ir;
    logic [DATA_W-1:0] data;
  } pend_t;

  pend_t                        pend_q[$];
  logic [IR_W+DATA_W-1:0]       model_q[$];
  logic                         ov_m, ack_m, pulse_m;
  logic [IR_W-1:0]              irl_m;

  // Monitor: compare current outputs with the model, then advance the model
  // across the coming edge using the inputs that edge will sample.
  always @(negedge clk) begin
    if (!reset_n) begin
      model_q.delete();
      pend_q.delete();
      ov_m = 1'b0; ack_m = 1'b0; pulse_m = 1'b0; irl_m = '0;
    end else begin
      automatic bit    popped  = 1'b0;
      automatic bit    dropped = 1'b0;
      automatic bit    pls     = 1'b0;
      automatic pend_t keep_q[$];
      chk("cmd_valid", 64'(cmd_valid), 64'(model_q.size() != 0));
      chk("level", 64'(level), 64'(model_q.size()));
      chk("overflow", 64'(overflow), 64'(ov_m));
      chk("ack_toggle", 64'(ack_toggle), 64'(ack_m));
      chk("uir_pulse", 64'(uir_pulse), 64'(pulse_m));
      chk("ir_latched", 64'(ir_latched), 64'(irl_m));
      if (model_q.size() != 0)
        chk("head", 64'({cmd_ir, cmd_data}), 64'(model_q[0]));
      if (model_q.size() != 0 && cmd_ready) begin
        $display("pop  cycle %0d ir=%0h data=%0h", cyc, model_q[0][DATA_W+:IR_W], model_q[0][DATA_W-1:0]);
        void'(model_q.pop_front());
        ack_m  = ~ack_m;
        popped = 1'b1;
      end
      foreach (pend_q[i]) begin
        if (pend_q[i].edge_no == cyc + 1) begin
          if (pend_q[i].is_uir) begin
            pls   = 1'b1;
            irl_m = pend_q[i].ir;
          end else if (model_q.size() < DEPTH) begin
            model_q.push_back({pend_q[i].ir, pend_q[i].data});
          end else begin
            dropped = 1'b1;
          end
        end else begin
          keep_q.push_back(pend_q[i]);
        end
      end
      pend_q  = keep_q;
      pulse_m = pls;
      if (dropped)           ov_m = 1'b1;
      else if (overflow_clr) ov_m = 1'b0;
      if (popped && dropped) $display("FAIL model_order at cycle %0d", cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One strobe pulse. The rise acts on the third edge after the strobe goes
  // high; ready_w/clr_w drive cmd_ready/overflow_clr for exactly that edge.
  task automatic strobe(input bit do_udr, input bit do_uir,
                        input logic [IR_W-1:0] ir, input logic [DATA_W-1:0] d,
                        input bit ready_w, input bit clr_w);
    pend_t p;
    ir_in = ir; sr = d;
    vs_udr = do_udr; vs_uir = do_uir;
    p.edge_no = cyc + 3; p.ir = ir; p.data = d;
    if (do_udr) begin p.is_uir = 1'b0; pend_q.push_back(p); end
    if (do_uir) begin p.is_uir = 1'b1; pend_q.push_back(p); end
    $display("cmd  cycle %0d udr=%0b uir=%0b ir=%0h data=%0h", cyc, do_udr, do_uir, ir, d);
    tick();
    tick();
    cmd_ready = ready_w; overflow_clr = clr_w;
    tick();
    cmd_ready = 1'b0; overflow_clr = 1'b0;
    tick();
    vs_udr = 1'b0; vs_uir = 1'b0;
    repeat (3) tick();
  endtask

  task automatic drain(input int n);
    cmd_ready = 1'b1;
    repeat (n) tick();
    cmd_ready = 1'b0;
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(cmd_valid), 64'd0);
    chk({tag, "_level"}, 64'(level), 64'd0);
    chk({tag, "_head"}, 64'({cmd_ir, cmd_data}), 64'd0);
    chk({tag, "_flags"}, 64'({overflow, ack_toggle, uir_pulse, ir_latched}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; vs_udr = 1'b0; vs_uir = 1'b0; ir_in = '0; sr = '0;
    cmd_ready = 1'b0; overflow_clr = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    reset_n = 1'b1;
    tick();

    // Single command, then consume it
    strobe(1, 0, 2'b01, 38'h2A_5A5A_5A5A, 0, 0);
    chk("t1_level", 64'(level), 64'd1);
    chk("t1_data", 64'({cmd_ir, cmd_data}), 64'({2'b01, 38'h2A_5A5A_5A5A}));
    drain(2);

    // Five commands into a four-deep FIFO: last one dropped
    for (int i = 1; i <= 5; i++) strobe(1, 0, 2'b10, 38'(i), 0, 0);
    chk("t2_level", 64'(level), 64'd4);
    chk("t2_overflow", 64'(overflow), 64'd1);
    drain(6);
    overflow_clr = 1'b1; tick(); overflow_clr = 1'b0; tick();
    chk("t2_clr", 64'(overflow), 64'd0);

    // Full FIFO with a pop on the same edge as the fifth push
    for (int i = 0; i < 4; i++) strobe(1, 0, 2'b00, 38'(16 + i), 0, 0);
    strobe(1, 0, 2'b11, 38'h3F_0000_0001, 1, 0);
    chk("t3_level", 64'(level), 64'd4);
    chk("t3_overflow", 64'(overflow), 64'd0);

    // Drop and clear on the same edge: flag stays set; clear alone then wins
    strobe(1, 0, 2'b01, 38'h15, 0, 1);
    chk("t4_overflow", 64'(overflow), 64'd1);
    overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
    chk("t4_clr", 64'(overflow), 64'd0);
    drain(6);

    // Update-IR alone, then simultaneous update-DR and update-IR
    strobe(0, 1, 2'b11, 38'h0, 0, 0);
    chk("t5_irl", 64'(ir_latched), 64'd3);
    chk("t5_level", 64'(level), 64'd0);
    strobe(1, 1, 2'b10, 38'h12_3456_789A, 0, 0);
    chk("t5_both_level", 64'(level), 64'd1);
    chk("t5_both_irl", 64'(ir_latched), 64'd2);
    drain(2);

    // Random phase
    for (int n = 0; n < 40; n++) begin
      automatic logic [DATA_W-1:0] d  = {6'($urandom()), 32'($urandom())};
      automatic logic [IR_W-1:0]   ir = 2'($urandom());
      automatic bit u = ($urandom_range(0, 3) != 0);
      automatic bit v = ($urandom_range(0, 3) == 0);
      strobe(u, v, ir, d, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
      for (int k = $urandom_range(0, 3); k > 0; k--) begin
        cmd_ready = 1'($urandom_range(0, 1));
        overflow_clr = ($urandom_range(0, 7) == 0);
        tick();
      end
      cmd_ready = 1'b0; overflow_clr = 1'b0;
    end
    drain(6);

    // Asynchronous reset with three entries queued
    for (int i = 0; i < 3; i++) strobe(1, 0, 2'b01, 38'(32 + i), 0, 0);
    chk("t6_level", 64'(level), 64'd3);
    #2 reset_n = 1'b0;
    #1 check_all_zero("async_reset");
    tick();
    reset_n = 1'b1;
    tick();
    strobe(1, 0, 2'b10, 38'h7, 0, 0);
    chk("t6_after_level", 64'(level), 64'd1);
    drain(3);
    chk("final_level", 64'(level), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
